// File: rtl/op_dispatcher_pkg.sv
// Shared op word, command codes and dispatcher state encoding for the op sequencing path.
// The state enum is exported so the processor debug view can decode dispatcher state.
package op_dispatcher_pkg;

  localparam int OP_ARG_W = 32;

  typedef logic [7:0] op_cmd_t;

  localparam op_cmd_t OP_CMD_G00 = 8'd0;
  localparam op_cmd_t OP_CMD_G01 = 8'd1;
  localparam op_cmd_t OP_CMD_G02 = 8'd2;
  localparam op_cmd_t OP_CMD_G03 = 8'd3;
  localparam op_cmd_t OP_CMD_G04 = 8'd4;
  localparam op_cmd_t OP_CMD_G28 = 8'd28;
  localparam op_cmd_t OP_CMD_G90 = 8'd90;
  localparam op_cmd_t OP_CMD_G91 = 8'd91;

  typedef struct packed {
    op_cmd_t                    cmd;
    logic signed [OP_ARG_W-1:0] arg0;
    logic signed [OP_ARG_W-1:0] arg1;
    logic signed [OP_ARG_W-1:0] arg2;
    logic signed [OP_ARG_W-1:0] arg3;
    logic signed [OP_ARG_W-1:0] arg4;
  } Op_st;

  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_TRIG  = 2'd1,
    DISP_WAIT  = 2'd2,
    DISP_DRAIN = 2'd3
  } OpDispatcherState_t;

endpackage

// File: rtl/op_dispatcher_if.sv
// Parser-side op handshake plus handler trigger/done, bundled for the dispatcher.
// The master modport is the dispatcher's view; slave is the parser/handler side.
interface op_dispatcher_if;
  import op_dispatcher_pkg::*;

  logic in_valid;
  logic in_ready;
  Op_st in_op;
  logic out_trigger;
  logic handler_done;

  modport master (
    input  in_valid,
    input  in_op,
    input  handler_done,
    output in_ready,
    output out_trigger
  );

  modport slave (
    output in_valid,
    output in_op,
    output handler_done,
    input  in_ready,
    input  out_trigger
  );

endinterface

// File: rtl/op_dispatcher_watchdog.sv
// Handler watchdog: cleared on trigger, counts while enabled, flags expiry on the last allowed cycle.
// TIMEOUT_CYCLES of 0 removes the counter entirely.
module op_watchdog #(
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, enable};
    assign expire        = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturate at LAST so a stalled enable can never wrap back to a non-expired value.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expire = enable && (cnt_q == LAST);
  end

endmodule

// File: rtl/op_dispatcher.sv
// Op dispatcher: accepts one parsed op, pulses the handler trigger, waits for done,
// then drains a level-held done before accepting the next op.
module op_dispatcher
  import op_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int COUNT_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  op_dispatcher_if.master       bus,
  input  logic                  abort,
  output Op_st                  out_op,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [COUNT_BITS-1:0] done_count
);

  localparam logic [1:0] ST_IDLE  = DISP_IDLE;
  localparam logic [1:0] ST_TRIG  = DISP_TRIG;
  localparam logic [1:0] ST_WAIT  = DISP_WAIT;
  localparam logic [1:0] ST_DRAIN = DISP_DRAIN;

  logic [1:0]            state_q, state_d;
  Op_st                  op_q, op_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  err_q, err_d;
  logic                  wd_clear, wd_enable, wd_expire;

  assign wd_clear  = (state_q == ST_TRIG);
  assign wd_enable = (state_q == ST_WAIT);

  op_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  // Abort outranks everything, including an accept or a done arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else if (bus.in_valid) begin
          op_d    = bus.in_op;
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        state_d = abort ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else if (bus.handler_done) begin
          count_d = count_q + COUNT_BITS'(1);
          state_d = ST_DRAIN;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!abort && !bus.handler_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Ready is held low while reset is asserted so nothing is offered to a dispatcher in reset.
  assign bus.in_ready    = (state_q == ST_IDLE) && !abort && !reset;
  assign bus.out_trigger = (state_q == ST_TRIG);
  assign busy            = (state_q != ST_IDLE);
  assign out_op          = op_q;
  assign timeout_err     = err_q;
  assign done_count      = count_q;

endmodule

// File: tb/tb_op_dispatcher.sv
// Self-checking bench for op_dispatcher: directed scenarios plus randomized op/done timing
// checked against expected cycle positions derived from the handshake rules.
module tb_op_dispatcher;
  import op_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  Op_st        out_op;
  logic        busy;
  logic        timeout_err;
  logic [15:0] done_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count;
  logic        exp_err;

  op_cmd_t cmd_tab [8] = '{OP_CMD_G00, OP_CMD_G01, OP_CMD_G02, OP_CMD_G03,
                           OP_CMD_G04, OP_CMD_G28, OP_CMD_G90, OP_CMD_G91};

  op_dispatcher_if bus ();

  op_dispatcher #(
    .TIMEOUT_CYCLES(8),
    .COUNT_BITS    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .abort      (abort),
    .out_op     (out_op),
    .busy       (busy),
    .timeout_err(timeout_err),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, in_ready, out_trigger}
  function automatic logic [2:0] stat();
    return {busy, bus.in_ready, bus.out_trigger};
  endfunction

  function automatic Op_st mk_op(op_cmd_t c, int a0, int a1);
    Op_st o;
    o      = '0;
    o.cmd  = c;
    o.arg0 = a0;
    o.arg1 = a1;
    return o;
  endfunction

  function automatic Op_st rand_op();
    Op_st o;
    o.cmd  = cmd_tab[$urandom_range(0, 7)];
    o.arg0 = $urandom;
    o.arg1 = $urandom;
    o.arg2 = $urandom;
    o.arg3 = $urandom;
    o.arg4 = $urandom;
    return o;
  endfunction

  // One full op: accept now, trigger next cycle, done d cycles after trigger held for len cycles.
  task automatic do_op(input Op_st op, input int d, input int len, input string tag);
    bus.in_valid = 1'b1; bus.in_op = op; abort = 1'b0; bus.handler_done = 1'b0;
    #1;
    checks++; if (stat() !== 3'b010) begin errors++; $display("FAIL %s_accept stat got=%b exp=010", tag, stat()); end
    tick();
    bus.in_op = rand_op();
    #1;
    checks++; if (stat() !== 3'b101) begin errors++; $display("FAIL %s_trigger stat got=%b exp=101", tag, stat()); end
    checks++; if (out_op !== op) begin errors++; $display("FAIL %s_trig_op got=%h exp=%h", tag, out_op, op); end
    tick();
    for (int k = 1; k < d; k++) begin
      #1;
      checks++; if (stat() !== 3'b100) begin errors++; $display("FAIL %s_wait stat got=%b exp=100", tag, stat()); end
      checks++; if (out_op !== op) begin errors++; $display("FAIL %s_wait_op got=%h exp=%h", tag, out_op, op); end
      tick();
    end
    for (int k = 0; k < len; k++) begin
      bus.handler_done = 1'b1;
      #1;
      checks++; if (stat() !== 3'b100) begin errors++; $display("FAIL %s_done stat got=%b exp=100", tag, stat()); end
      checks++; if (done_count !== exp_count) begin errors++; $display("FAIL %s_done_cnt got=%0d exp=%0d", tag, done_count, exp_count); end
      tick();
      if (k == 0) exp_count = exp_count + 16'd1;
    end
    bus.handler_done = 1'b0;
    #1;
    checks++; if (stat() !== 3'b100) begin errors++; $display("FAIL %s_drain stat got=%b exp=100", tag, stat()); end
    checks++; if (done_count !== exp_count) begin errors++; $display("FAIL %s_drain_cnt got=%0d exp=%0d", tag, done_count, exp_count); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (stat() !== 3'b010) begin errors++; $display("FAIL %s_idle stat got=%b exp=010", tag, stat()); end
    checks++; if (done_count !== exp_count) begin errors++; $display("FAIL %s_idle_cnt got=%0d exp=%0d", tag, done_count, exp_count); end
    checks++; if (timeout_err !== exp_err) begin errors++; $display("FAIL %s_err got=%b exp=%b", tag, timeout_err, exp_err); end
    checks++; if (out_op !== op) begin errors++; $display("FAIL %s_idle_op got=%h exp=%h", tag, out_op, op); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (stat() !== 3'b000) begin errors++; $display("FAIL reset_stat got=%b exp=000", stat()); end
    checks++; if (out_op !== Op_st'('0)) begin errors++; $display("FAIL reset_op got=%h exp=0", out_op); end
    checks++; if ({timeout_err, done_count} !== 17'd0) begin errors++; $display("FAIL reset_err_cnt got=%b/%0d exp=0/0", timeout_err, done_count); end
    reset = 1'b0;
    #1;
    checks++; if (stat() !== 3'b010) begin errors++; $display("FAIL reset_release stat got=%b exp=010", stat()); end
    tick();
  endtask

  task automatic test_basic();
    do_op(mk_op(OP_CMD_G01, 100, 50), 4, 1, "basic");
  endtask

  task automatic test_back_to_back();
    Op_st    ops [3];
    op_cmd_t seen [$];
    int      idx     = 0;
    int      done_at = -1;
    logic    acc;
    ops[0] = mk_op(OP_CMD_G00, 1, 2);
    ops[1] = mk_op(OP_CMD_G02, -3, 4);
    ops[2] = mk_op(OP_CMD_G90, 5, -6);
    for (int c = 0; c < 40; c++) begin
      bus.in_valid     = (idx < 3);
      bus.in_op        = (idx < 3) ? ops[idx] : rand_op();
      bus.handler_done = (c == done_at);
      #1;
      if (bus.out_trigger) begin
        checks++;
        if (seen.size() < 3 && out_op !== ops[seen.size()]) begin
          errors++; $display("FAIL b2b_op got=%h exp=%h", out_op, ops[seen.size()]);
        end
        seen.push_back(out_op.cmd);
        done_at = c + 3;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0; bus.handler_done = 1'b0;
    exp_count = exp_count + 16'd3;
    #1;
    checks++; if (seen.size() != 3) begin errors++; $display("FAIL b2b_triggers got=%0d exp=3", seen.size()); end
    for (int i = 0; i < seen.size() && i < 3; i++) begin
      checks++; if (seen[i] !== ops[i].cmd) begin errors++; $display("FAIL b2b_cmd%0d got=%0d exp=%0d", i, seen[i], ops[i].cmd); end
    end
    checks++; if (done_count !== exp_count) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", done_count, exp_count); end
    checks++; if (stat() !== 3'b010) begin errors++; $display("FAIL b2b_idle stat got=%b exp=010", stat()); end
  endtask

  task automatic test_level_done();
    do_op(mk_op(OP_CMD_G02, 7, 8), 2, 10, "level");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        #1;
        checks++; if (stat() !== 3'b010) begin errors++; $display("FAIL rnd_gap stat got=%b exp=010", stat()); end
      end
      do_op(rand_op(), $urandom_range(1, 6), $urandom_range(1, 4), "rnd");
    end
  endtask

  task automatic test_watchdog();
    Op_st op = rand_op();
    do_op(rand_op(), 8, 1, "donewins");
    bus.in_valid = 1'b1; bus.in_op = op;
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (stat() !== 3'b101) begin errors++; $display("FAIL wd_trigger stat got=%b exp=101", stat()); end
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++; if ({timeout_err, stat()} !== 4'b0100) begin errors++; $display("FAIL wd_wait%0d err/stat got=%b exp=0100", k, {timeout_err, stat()}); end
      tick();
    end
    #1;
    checks++; if ({timeout_err, stat()} !== 4'b1100) begin errors++; $display("FAIL wd_fire err/stat got=%b exp=1100", {timeout_err, stat()}); end
    checks++; if (done_count !== exp_count) begin errors++; $display("FAIL wd_count got=%0d exp=%0d", done_count, exp_count); end
    tick();
    #1;
    checks++; if (stat() !== 3'b010) begin errors++; $display("FAIL wd_idle stat got=%b exp=010", stat()); end
    exp_err = 1'b1;
    do_op(rand_op(), 3, 1, "after_wd");
  endtask

  task automatic test_abort();
    Op_st a = rand_op();
    Op_st b = rand_op();
    bus.in_valid = 1'b1; bus.in_op = a;
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (stat() !== 3'b101) begin errors++; $display("FAIL abort_trigger stat got=%b exp=101", stat()); end
    tick();
    tick();
    abort = 1'b1; bus.handler_done = 1'b1;
    #1;
    tick();
    abort = 1'b0; bus.handler_done = 1'b0;
    #1;
    checks++; if (stat() !== 3'b100) begin errors++; $display("FAIL abort_drain stat got=%b exp=100", stat()); end
    checks++; if (done_count !== exp_count) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", done_count, exp_count); end
    tick();
    #1;
    checks++; if ({timeout_err, stat()} !== {exp_err, 3'b010}) begin errors++; $display("FAIL abort_idle err/stat got=%b exp=%b", {timeout_err, stat()}, {exp_err, 3'b010}); end
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_op = b;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready got=%b exp=0", bus.in_ready); end
    tick();
    abort = 1'b0;
    #1;
    checks++; if (stat() !== 3'b100) begin errors++; $display("FAIL abort_idle_drain stat got=%b exp=100", stat()); end
    checks++; if (out_op !== a) begin errors++; $display("FAIL abort_held_op got=%h exp=%h", out_op, a); end
    tick();
    do_op(b, 3, 1, "post_abort");
  endtask

  task automatic test_reset_midwait();
    bus.in_valid = 1'b1; bus.in_op = mk_op(OP_CMD_G03, 9, 9);
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (stat() !== 3'b000) begin errors++; $display("FAIL rst_mid stat got=%b exp=000", stat()); end
    checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", done_count); end
    checks++; if (out_op.cmd !== OP_CMD_G00) begin errors++; $display("FAIL rst_mid_cmd got=%0d exp=0", out_op.cmd); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got=%b exp=0", timeout_err); end
    #3;
    reset = 1'b0;
    exp_count = 16'd0;
    exp_err   = 1'b0;
    tick();
    do_op(rand_op(), 2, 2, "post_rst");
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.handler_done = 1'b0;
    exp_count = 16'd0; exp_err = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_level_done();
    test_random();
    test_watchdog();
    test_abort();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
